// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and data-miss freeze control for the five-stage RV32I pipeline.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1e,
    input  logic [REG_ADDR_WIDTH-1:0] rs2e,
    input  logic [REG_ADDR_WIDTH-1:0] rde,
    input  logic [REG_ADDR_WIDTH-1:0] rdm,
    input  logic [REG_ADDR_WIDTH-1:0] rdw,
    input  logic                      regwritem,
    input  logic                      regwritew,
    input  logic                      loade,
    input  logic                      pcsrce,
    input  logic                      memaccm,
    input  logic                      hitm,
    input  logic                      mem_ready,
    output logic [1:0]                forwardae,
    output logic [1:0]                forwardbe,
    output logic                      stallf,
    output logic                      stalld,
    output logic                      stalle,
    output logic                      stallm,
    output logic                      stallw,
    output logic                      flushd,
    output logic                      flushe,
    output logic                      mem_req,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    typedef enum logic [1:0] {IDLE, MISS, REFILL} state_t;

    state_t state_q, state_d;
    logic   mem_req_q, mem_req_d;
    logic   miss, freeze, lwstall;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] rd_m,
        input logic [REG_ADDR_WIDTH-1:0] rd_w,
        input logic                      we_m,
        input logic                      we_w
    );
        if (rs == '0)                  return 2'b00;
        else if (we_m && rd_m == rs)   return 2'b10;
        else if (we_w && rd_w == rs)   return 2'b01;
        else                           return 2'b00;
    endfunction

    always_comb begin
        fwd_a   = fwd_sel(rs1e, rdm, rdw, regwritem, regwritew);
        fwd_b   = fwd_sel(rs2e, rdm, rdw, regwritem, regwritew);
        lwstall = loade && (rde != '0) && ((rde == rs1d) || (rde == rs2d));
        miss    = memaccm && !hitm;
        // Freeze starts in the detection cycle, before the FSM has left IDLE.
        freeze  = (state_q != IDLE) || miss;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss)      state_d = MISS;
            MISS:    if (mem_ready) state_d = REFILL;
            REFILL:                 state_d = IDLE;
            default:                state_d = IDLE;
        endcase
        mem_req_d = (state_d == MISS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
        end
    end

    // Hazard squashes are masked while frozen; D and E are held so they re-resolve on release.
    always_comb begin
        forwardae = freeze ? 2'b00 : fwd_a;
        forwardbe = freeze ? 2'b00 : fwd_b;
        stallf    = freeze || lwstall;
        stalld    = freeze || lwstall;
        stalle    = freeze;
        stallm    = freeze;
        stallw    = freeze;
        flushd    = !freeze && pcsrce;
        flushe    = !freeze && (pcsrce || lwstall);
        mem_req   = mem_req_q;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stallf && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if ((flushd || flushe) && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a behavioural pipeline model.
module tb_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic regwritem, regwritew, loade, pcsrce, memaccm, hitm, mem_ready;
    logic [1:0] forwardae, forwardbe;
    logic stallf, stalld, stalle, stallm, stallw, flushd, flushe, mem_req;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Model: miss_wait = refill requested and outstanding; refill_cyc = the one cycle after data returns.
    bit miss_wait, refill_cyc;
    longint unsigned m_stall, m_flush;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e),
        .rde(rde), .rdm(rdm), .rdw(rdw),
        .regwritem(regwritem), .regwritew(regwritew),
        .loade(loade), .pcsrce(pcsrce), .memaccm(memaccm), .hitm(hitm),
        .mem_ready(mem_ready),
        .forwardae(forwardae), .forwardbe(forwardbe),
        .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm), .stallw(stallw),
        .flushd(flushd), .flushe(flushe), .mem_req(mem_req),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic bit frozen();
        return miss_wait || refill_cyc || (memaccm && !hitm);
    endfunction

    function automatic bit load_use();
        return loade && rde != 0 && (rde == rs1d || rde == rs2d);
    endfunction

    function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
        if (frozen() || rs == 0) return 2'b00;
        if (regwritem && rdm == rs) return 2'b10;
        if (regwritew && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk1(input string tag, input string sig, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, sig, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit fz, lu, e_fd, e_fe;
        fz = frozen();
        lu = load_use();
        e_fd = !fz && pcsrce;
        e_fe = !fz && (pcsrce || lu);
        chk1(tag, "forwardae", {30'd0, forwardae}, {30'd0, fwd(rs1e)});
        chk1(tag, "forwardbe", {30'd0, forwardbe}, {30'd0, fwd(rs2e)});
        chk1(tag, "stallf", {31'd0, stallf}, {31'd0, fz || lu});
        chk1(tag, "stalld", {31'd0, stalld}, {31'd0, fz || lu});
        chk1(tag, "stalle", {31'd0, stalle}, {31'd0, fz});
        chk1(tag, "stallm", {31'd0, stallm}, {31'd0, fz});
        chk1(tag, "stallw", {31'd0, stallw}, {31'd0, fz});
        chk1(tag, "flushd", {31'd0, flushd}, {31'd0, e_fd});
        chk1(tag, "flushe", {31'd0, flushe}, {31'd0, e_fe});
        chk1(tag, "mem_req", {31'd0, mem_req}, {31'd0, miss_wait});
`ifdef HAZARD_PERF_CNT_EN
        chk1(tag, "stall_cnt", stall_cnt, CW'(m_stall));
        chk1(tag, "flush_cnt", flush_cnt, CW'(m_flush));
`else
        chk1(tag, "stall_cnt", stall_cnt, '0);
        chk1(tag, "flush_cnt", flush_cnt, '0);
`endif
    endtask

    task automatic model_clock();
        bit fz, lu;
        fz = frozen();
        lu = load_use();
        if (fz || lu) m_stall = (m_stall == 64'hFFFF_FFFF) ? m_stall : m_stall + 1;
        if (!fz && (pcsrce || lu)) m_flush = (m_flush == 64'hFFFF_FFFF) ? m_flush : m_flush + 1;
        if (refill_cyc) refill_cyc = 0;
        else if (miss_wait) begin
            if (mem_ready) begin
                miss_wait = 0;
                refill_cyc = 1;
            end
        end else if (memaccm && !hitm) miss_wait = 1;
    endtask

    // One cycle: settle, compare against model, clock, advance model.
    task automatic cyc(input string tag);
        #2;
        check_all(tag);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic clr();
        {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
        {regwritem, regwritew, loade, pcsrce, memaccm, mem_ready} = '0;
        hitm = 1'b1;
    endtask

    task automatic model_reset();
        miss_wait = 0;
        refill_cyc = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    initial begin
        clr();
        model_reset();
        rst_n = 1'b0;
        #3;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Three-cycle miss followed by one load-use stall.
        memaccm = 1; hitm = 0;               cyc("cnt_detect");
        hitm = 1; mem_ready = 1;             cyc("cnt_miss");
        mem_ready = 0;                       cyc("cnt_refill");
        memaccm = 0; loade = 1; rde = 7; rs2d = 7; cyc("cnt_lu");
        clr();
        #2;
`ifdef HAZARD_PERF_CNT_EN
        chk1("cnt_total", "stall_cnt", stall_cnt, 32'd4);
        chk1("cnt_total", "flush_cnt", flush_cnt, 32'd1);
`else
        chk1("cnt_total", "stall_cnt", stall_cnt, 32'd0);
        chk1("cnt_total", "flush_cnt", flush_cnt, 32'd0);
`endif
        cyc("cnt_after");

        // Forwarding priority.
        rs1e = 5; rdm = 5; rdw = 5; regwritem = 1; regwritew = 1;
        #2 chk1("fwd_m", "forwardae", {30'd0, forwardae}, 32'd2);
        cyc("fwd_m");
        regwritem = 0;
        #2 chk1("fwd_w", "forwardae", {30'd0, forwardae}, 32'd1);
        cyc("fwd_w");
        rs1e = 0;
        #2 chk1("fwd_x0", "forwardae", {30'd0, forwardae}, 32'd0);
        cyc("fwd_x0");
        clr();

        // Load-use with and without x0 destination.
        loade = 1; rde = 7; rs2d = 7;
        #2 chk1("lu", "flushd", {31'd0, flushd}, 32'd0);
        cyc("lu");
        rde = 0;                             cyc("lu_x0");
        clr();

        // Branch and load-use together.
        pcsrce = 1; loade = 1; rde = 3; rs1d = 3;
        #2 chk1("br_lu", "flushd", {31'd0, flushd}, 32'd1);
        cyc("br_lu");
        clr();

        // Miss timeline: detect in cycle 0, mem_ready in cycle 4, release in cycle 6.
        for (int c = 0; c <= 6; c++) begin
            clr();
            memaccm = 1;
            hitm = (c != 0);
            pcsrce = (c == 2);
            mem_ready = (c == 4);
            if (c == 2) begin
                #2 chk1("miss_br", "flushd", {31'd0, flushd}, 32'd0);
            end
            if (c == 6) begin
                #2 chk1("miss_rel", "stallf", {31'd0, stallf}, 32'd0);
            end
            cyc($sformatf("miss_c%0d", c));
        end
        clr();

        // Asynchronous reset in the middle of MISS.
        memaccm = 1; hitm = 0;               cyc("rst_detect");
        clr();                               cyc("rst_miss");
        rst_n = 1'b0;
        model_reset();
        #1;
        chk1("rst_async", "stallf", {31'd0, stallf}, 32'd0);
        chk1("rst_async", "mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1;                       cyc("rst_ready_ignored");
        mem_ready = 0;                       cyc("rst_idle");

        // Randomized traffic with small register indices so matches happen often.
        for (int i = 0; i < 400; i++) begin
            rs1d = AW'($urandom_range(0, 3));
            rs2d = AW'($urandom_range(0, 3));
            rs1e = AW'($urandom_range(0, 3));
            rs2e = AW'($urandom_range(0, 3));
            rde  = AW'($urandom_range(0, 3));
            rdm  = AW'($urandom_range(0, 3));
            rdw  = AW'($urandom_range(0, 3));
            regwritem = 1'($urandom);
            regwritew = 1'($urandom);
            loade     = ($urandom_range(0, 3) == 0);
            pcsrce    = ($urandom_range(0, 4) == 0);
            memaccm   = 1'($urandom);
            hitm      = ($urandom_range(0, 5) != 0);
            mem_ready = ($urandom_range(0, 3) == 0);
            cyc($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
